// File: rtl/imm_extend_pipe_pkg.sv
// Shared types and helpers for the pipelined immediate generator.
// The optional illegal-mode counter is enabled by IMM_EXT_ERRCNT_EN.
package imm_ext_pkg;

    typedef enum logic [1:0] {
        IMM_ROT8    = 2'b00,
        IMM_U12     = 2'b01,
        IMM_BR      = 2'b10,
        IMM_ILLEGAL = 2'b11
    } immsrc_t;

    // Tag field is sized for the widest supported sideband; unused upper bits stay zero.
    localparam int TAG_MAX_W = 16;
    localparam int ROT_UNIT  = 2;

    typedef struct packed {
        logic [31:0]          imm;
        logic                 carry;
        logic                 err;
        logic [TAG_MAX_W-1:0] tag;
    } stage_t;

    function automatic logic [31:0] ror32(input logic [31:0] v, input logic [4:0] r);
        logic [5:0] lsh;
        lsh = 6'd32 - {1'b0, r};
        // r == 0 is kept separate so the 32-bit shift never participates.
        if (r == 5'd0) begin
            return v;
        end else begin
            return (v >> r) | (v << lsh);
        end
    endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute handshake bundle for imm_extend_pipe (IMM_EXT_ERRCNT_EN
// affects only the separate err_count port, not this interface).
interface imm_ext_if #(parameter int TAG_W = 4);
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_instr;
    logic [1:0]       in_immsrc;
    logic             in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_imm;
    logic             out_carry;
    logic             out_err;
    logic [TAG_W-1:0] out_tag;

    modport slave (
        input  in_valid, in_instr, in_immsrc, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_carry, out_err, out_tag
    );

    modport master (
        output in_valid, in_instr, in_immsrc, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_carry, out_err, out_tag
    );
endinterface

// File: rtl/imm_extend_pipe_calc.sv
// Combinational mode decode, rotate and branch extension feeding stage 0.
// Independent of IMM_EXT_ERRCNT_EN.
module imm_ext_calc
    import imm_ext_pkg::*;
#(
    parameter int BR_SHIFT = 2
) (
    input  logic [23:0] instr_i,
    input  logic [1:0]  immsrc_i,
    input  logic        carry_i,
    output logic [31:0] imm_o,
    output logic        carry_o,
    output logic        err_o
);

    logic [4:0]  rot_s;
    logic [31:0] rot_imm_s;
    logic [31:0] br_sext_s;

    assign rot_s     = 5'({1'b0, instr_i[11:8]} * 5'(ROT_UNIT));
    assign rot_imm_s = ror32({24'd0, instr_i[7:0]}, rot_s);
    assign br_sext_s = {{8{instr_i[23]}}, instr_i};

    // Select result, carry-out and error flag by immediate source.
    always_comb begin
        imm_o   = 32'd0;
        carry_o = carry_i;
        err_o   = 1'b0;
        case (immsrc_t'(immsrc_i))
            IMM_ROT8: begin
                imm_o   = rot_imm_s;
                carry_o = (rot_s == 5'd0) ? carry_i : rot_imm_s[31];
            end
            IMM_U12: begin
                imm_o = {20'd0, instr_i[11:0]};
            end
            IMM_BR: begin
                imm_o = br_sext_s << BR_SHIFT;
            end
            IMM_ILLEGAL: begin
                err_o = 1'b1;
            end
            default: begin
                imm_o = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate generator: STAGES-deep valid/ready pipe around imm_ext_calc.
// Define IMM_EXT_ERRCNT_EN to build the saturating illegal-mode counter.
module imm_extend_pipe
    import imm_ext_pkg::*;
#(
    parameter int STAGES   = 2,   // 1..4
    parameter int TAG_W    = 4,   // 1..TAG_MAX_W
    parameter int BR_SHIFT = 2    // 0..3
) (
    input  logic        clk,
    input  logic        reset,
    imm_ext_if.slave    bus,
    output logic [15:0] err_count
);

    logic [STAGES-1:0] valid_q;
    stage_t            payload_q [STAGES];
    stage_t            payload_d;
    logic              advance_s;
    logic              in_fire_s;
    logic              out_fire_s;
    logic [31:0]       calc_imm_s;
    logic              calc_carry_s;
    logic              calc_err_s;

    imm_ext_calc #(.BR_SHIFT(BR_SHIFT)) u_calc (
        .instr_i  (bus.in_instr),
        .immsrc_i (bus.in_immsrc),
        .carry_i  (bus.in_carry),
        .imm_o    (calc_imm_s),
        .carry_o  (calc_carry_s),
        .err_o    (calc_err_s)
    );

    assign advance_s    = !valid_q[STAGES-1] || bus.out_ready;
    assign in_fire_s    = bus.in_valid && advance_s;
    assign out_fire_s   = valid_q[STAGES-1] && bus.out_ready;
    assign bus.in_ready = advance_s;

    // Stage-0 payload; bubbles carry zeros so idle outputs read 0.
    always_comb begin
        payload_d = '0;
        if (in_fire_s) begin
            payload_d.imm   = calc_imm_s;
            payload_d.carry = calc_carry_s;
            payload_d.err   = calc_err_s;
            payload_d.tag   = TAG_MAX_W'(bus.in_tag);
        end else begin
            payload_d = '0;
        end
    end

    // Lock-step shift of every stage on advance; all stages hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                payload_q[s] <= '0;
            end
        end else if (advance_s) begin
            valid_q[0]   <= in_fire_s;
            payload_q[0] <= payload_d;
            for (int s = 1; s < STAGES; s++) begin
                valid_q[s]   <= valid_q[s-1];
                payload_q[s] <= payload_q[s-1];
            end
        end
    end

    assign bus.out_valid = valid_q[STAGES-1];
    assign bus.out_imm   = payload_q[STAGES-1].imm;
    assign bus.out_carry = payload_q[STAGES-1].carry;
    assign bus.out_err   = payload_q[STAGES-1].err;
    assign bus.out_tag   = payload_q[STAGES-1].tag[TAG_W-1:0];

`ifdef IMM_EXT_ERRCNT_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;

    // Count illegal beats as they leave, saturating at all-ones.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_fire_s && bus.out_err && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_cnt_q <= 16'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`else
    logic unused_fire_s;
    assign unused_fire_s = out_fire_s;
    assign err_count     = 16'h0000;
`endif

endmodule

// File: doc/imm_extend_pipe.md
Name: imm_extend_pipe

Overview:
Pipelined, parametrised immediate generator for the pipelined ARM core. It replaces the single-cycle immediate extender. It accepts the 24-bit instruction field plus an immediate-source select and produces a 32-bit extended/rotated immediate, the shifter carry-out and an illegal-mode flag. Values move through a valid/ready pipeline of configurable depth, with a sideband tag carried alongside. It sits between decode and execute. It also serves the Thumb-style branch variant through a configurable branch shift.

Parameters:
STAGES, 2, register stages between input and output; legal 1..4; latency = STAGES cycles with no stall.
TAG_W, 4, width of the sideband tag carried through unchanged.
BR_SHIFT, 2, left shift applied to the branch offset (2 = ARM, 1 = Thumb); legal 0..3.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_instr  input  24  instruction bits [23:0]
in_immsrc  input  2  00 rotated imm8, 01 imm12 zero-extend, 10 branch, 11 illegal
in_carry  input  1  current CPSR C flag
in_tag  input  TAG_W  sideband tag
out_valid  output  1  output beat valid
out_ready  input  1  consumer accepts the output beat
out_imm  output  32  extended immediate
out_carry  output  1  shifter carry-out
out_err  output  1  beat came from illegal mode 11
out_tag  output  TAG_W  tag of the output beat
err_count  output  16  illegal-mode counter (optional feature)

Behaviour:
- One clock. Reset is synchronous and active-high.
- Reset clears every stage valid bit. All outputs read 0 during reset and until the first beat emerges. A reset asserted mid-stream discards all in-flight beats; nothing is emitted afterwards.
- Pipeline control:
  - advance = !out_valid || out_ready.
  - in_ready = advance.
  - A beat is accepted when in_valid && in_ready.
  - On advance, every stage shifts forward one position. Each stage's valid bit takes the previous stage's valid bit; stage 0 takes in_valid && in_ready.
  - When advance is low, all stages hold. Bubbles are not compressed.
- Output stability: while out_valid && !out_ready, out_imm, out_carry, out_err and out_tag stay unchanged.
- Ordering: strictly FIFO. No beat is lost or duplicated under any pattern of out_ready.
- Zero-latency pass-through is prohibited, even with STAGES = 1.
- Computation happens at stage 0 input. Later stages only carry results forward.
- Mode 00 (rotated imm8):
  - rot = {instr[11:8], 0}.
  - val = zero-extended instr[7:0].
  - out_imm = val rotated right by rot.
  - rot = 0 must give val unchanged. The 32-bit shift case must not be relied on.
  - out_carry = in_carry when rot = 0, else out_imm[31].
- Mode 01 (imm12): out_imm = zero-extended instr[11:0]; out_carry = in_carry.
- Mode 10 (branch): out_imm = sign-extended instr[23:0] shifted left by BR_SHIFT, truncated to 32 bits; out_carry = in_carry.
- Mode 11 (illegal): out_imm = 0, out_err = 1, out_carry = in_carry. The beat still flows through the pipeline normally.
- out_err = 0 for modes 00, 01 and 10.

Optional Feature:
Macro IMM_EXT_ERRCNT_EN.
- Defined: err_count starts at 0 on reset and increments by 1 for each mode-11 beat accepted at the output (out_valid && out_ready && out_err). It saturates at 0xFFFF.
- Undefined: err_count is tied to 0 and no counter flops are generated.

Decomposition:
- Package imm_ext_pkg holds:
  - the immsrc_t enum (IMM_ROT8, IMM_U12, IMM_BR, IMM_ILLEGAL);
  - the stage payload struct (imm, carry, err, tag);
  - constant ROT_UNIT = 2.
- One sub-module, imm_ext_calc, is the purely combinational mode decode and rotate used at stage 0. The top level owns the pipeline registers, handshake and counter.

Test Plan:
- Mode 00, instr[11:0] = 0x4FF, in_carry = 0 -> after 2 cycles out_imm = 0xFF000000, out_carry = 1, out_err = 0.
- Mode 00, instr[11:0] = 0x080, in_carry = 1 -> out_imm = 0x00000080, out_carry = 1 (rot = 0 path).
- Mode 10, instr = 0xFFFFFE -> out_imm = 0xFFFFFFF8. Mode 01, instr = 0x000ABC -> out_imm = 0x00000ABC.
- STAGES = 2: send 4 back-to-back beats with tags 1..4 while out_ready is held low for 3 cycles.
  - in_ready drops once the pipeline fills.
  - Outputs then appear in tag order 1, 2, 3, 4 with none lost or duplicated.
  - Outputs stay stable while stalled.
- Mode 11 beat -> out_imm = 0, out_err = 1. With IMM_EXT_ERRCNT_EN, err_count = 1 after the beat is accepted.
- Assert reset for one cycle with 2 beats in flight -> out_valid = 0 from the next cycle and neither beat is ever emitted.
